// File: rtl/pri_dec_pkg.sv
// pri_pkg: types and constants shared by the priority encoder/decoder pair.
package pri_pkg;
  localparam int PRI_W = 3;
  localparam int PRI_N = 8;
  typedef enum logic {IDLE, DRIVE} pri_dec_state_t;
  typedef logic [PRI_W-1:0] pri_code_t;
  typedef logic [PRI_N-1:0] pri_onehot_t;
endpackage

// File: rtl/pri_dec_if.sv
// pri_dec_if: code handshake plus decoded strobe between encoder side and decoder.
interface pri_dec_if #(parameter int W = pri_pkg::PRI_W);
  logic           in_valid;
  logic [W-1:0]   in_code;
  logic           in_ready;
  logic           flush;
  logic [2**W-1:0] out;
  logic           out_valid;
  modport master(output in_valid, in_code, flush, input in_ready, out, out_valid);
  modport slave(input in_valid, in_code, flush, output in_ready, out, out_valid);
endinterface

// File: rtl/pri_dec_bin2onehot.sv
// bin2onehot: combinational W-to-2**W binary to one-hot decoder.
module bin2onehot
  import pri_pkg::*;
#(
  parameter int W = PRI_W
) (
  input  logic [W-1:0]    i_code,
  output logic [2**W-1:0] o_onehot
);
  localparam int N = 2**W;
  assign o_onehot = N'(1) << i_code;
endmodule

// File: rtl/pri_dec.sv
// pri_dec: registered 3-to-8 priority-code decoder driving each accepted line for HOLD cycles.
module pri_dec
  import pri_pkg::*;
#(
  parameter int W    = PRI_W,
  parameter int HOLD = 4
) (
  input logic      clk,
  input logic      rst_n,
  pri_dec_if.slave bus
);
  localparam int CW = $clog2(HOLD + 1);
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("pri_dec: HOLD must be in 1..255");
  end
  pri_dec_state_t  r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [2**W-1:0] r_out, w_out_nx, w_onehot;
  logic            w_ready, w_acc, w_idle_nx;
  bin2onehot #(.W(W)) u_dec (.i_code(bus.in_code), .o_onehot(w_onehot));
  assign w_ready   = (r_state == IDLE || r_cnt == CW'(1)) && !bus.flush;
  assign w_acc     = bus.in_valid && w_ready;
  // flush wins; otherwise drop to idle only when nothing new arrives as the hold runs out
  assign w_idle_nx = bus.flush || (!w_acc && (r_state == IDLE || r_cnt == CW'(1)));
  always_comb begin
    w_state_nx = w_idle_nx ? IDLE : DRIVE;
    w_cnt_nx   = w_idle_nx ? '0 : w_acc ? CW'(HOLD) : r_cnt - 1'b1;
    w_out_nx   = w_idle_nx ? '0 : w_acc ? w_onehot : r_out;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_out   <= w_out_nx;
    end
  end
  assign bus.in_ready  = w_ready;
  assign bus.out       = r_out;
  assign bus.out_valid = (r_state == DRIVE);
endmodule
